// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: FSM states, writeback-select codes and the MEM/WB record.
// Also holds the default bus-timeout budget used when MEM_TIMEOUT_EN is defined.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'd0,
        WSEL_LOAD = 2'd1,
        WSEL_LINK = 2'd2,
        WSEL_ZERO = 2'd3
    } wsel_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    typedef struct packed {
        logic        halt;
        logic        write_reg;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the completed instruction or inserts a bubble.
// Latency: 1 cycle. Backpressure: none; a non-load cycle clears control and keeps data/rd.
import mem_pkg::*;

module mem_wb_reg (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  wb_t  wb_i,
    output wb_t  wb_o
);

    wb_t wb_q;
    wb_t wb_d;

    always_comb begin
        wb_d = wb_q;
        if (load_i) begin
            wb_d = wb_i;
        end else begin
            wb_d.halt      = 1'b0;
            wb_d.write_reg = 1'b0;
            wb_d.wb        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_o = wb_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory req/ready bus and feeds the MEM/WB register.
// Latency: 1 cycle zero-wait, N+1 with N wait states. Backpressure: mem_stall freezes upstream.
// Optional bus-timeout watchdog with sticky bus_err when MEM_TIMEOUT_EN is defined.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ext_stall,
    input  logic        M_Halt,
    input  logic        M_WriteReg,
    input  logic        M_WB,
    input  logic        M_ReadMem,
    input  logic        M_WriteMem,
    input  logic        M_JALC,
    input  logic [31:0] M_Num,
    input  logic [31:0] M_RegData_2,
    input  logic [4:0]  M_REG,
    input  logic [31:0] M_PCREG,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        W_Halt,
    output logic        W_WriteReg,
    output logic        W_WB,
    output logic [31:0] W_Data,
    output logic [4:0]  W_REG,
    output logic        bus_err
);

    mem_state_e state_q;
    logic       memop;
    logic       timeout;
    logic       acc_done;
    logic       complete;
    wsel_e      wsel;
    wb_t        wb_in;
    wb_t        wb_out;

    assign memop    = M_ReadMem | M_WriteMem;
    assign acc_done = dmem_ready | timeout;
    assign complete = ((state_q == ST_IDLE) & (~memop | dmem_ready))
                    | ((state_q == ST_WAIT) & acc_done);

    // Gated by reset so an abandoned access drops its request immediately.
    assign dmem_req   = reset & (((state_q == ST_IDLE) & memop) | (state_q == ST_WAIT));
    assign dmem_we    = dmem_req & M_WriteMem & ~M_ReadMem;
    assign dmem_addr  = M_Num;
    assign dmem_wdata = M_RegData_2;
    assign mem_stall  = dmem_req & ~acc_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (memop & ~dmem_ready) begin
                        state_q <= ST_WAIT;
                    end else if (ext_stall) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    if (acc_done) begin
                        state_q <= ext_stall ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!ext_stall) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             bus_err_q;

    assign timeout = (state_q == ST_WAIT) & ~dmem_ready
                   & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err = bus_err_q;

    // WAIT is only entered from IDLE, so clearing in IDLE resets the count on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign bus_err            = 1'b0;
`endif

    always_comb begin
        wsel = WSEL_ALU;
        if (M_ReadMem) begin
            wsel = dmem_ready ? WSEL_LOAD : WSEL_ZERO;
        end else if (M_JALC) begin
            wsel = WSEL_LINK;
        end
    end

    always_comb begin
        wb_in           = '0;
        wb_in.halt      = M_Halt;
        wb_in.write_reg = M_WriteReg;
        wb_in.wb        = M_WB;
        wb_in.rd        = M_REG;
        case (wsel)
            WSEL_LOAD: wb_in.data = dmem_rdata;
            WSEL_LINK: wb_in.data = M_PCREG;
            WSEL_ZERO: wb_in.data = 32'h0;
            default:   wb_in.data = M_Num;
        endcase
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i  (clock),
        .rst_ni (reset),
        .load_i (complete),
        .wb_i   (wb_in),
        .wb_o   (wb_out)
    );

    assign W_Halt     = wb_out.halt;
    assign W_WriteReg = wb_out.write_reg;
    assign W_WB       = wb_out.wb;
    assign W_Data     = wb_out.data;
    assign W_REG      = wb_out.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then randomized pipeline traffic against
// an instruction-level model (an instruction is either pending or already done and held).
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ext_stall = 1'b0;
    logic        M_Halt = 1'b0, M_WriteReg = 1'b0, M_WB = 1'b0;
    logic        M_ReadMem = 1'b0, M_WriteMem = 1'b0, M_JALC = 1'b0;
    logic [31:0] M_Num = '0, M_RegData_2 = '0, M_PCREG = '0;
    logic [4:0]  M_REG = '0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, mem_stall, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, W_Data;
    logic        W_Halt, W_WriteReg, W_WB;
    logic [4:0]  W_REG;

    int vectors = 0;
    int miscompares = 0;

    // Instruction-level reference state
    bit          m_done = 0;
    int          m_miss = 0;
    bit          m_err = 0;
    bit          m_halt = 0, m_wr = 0, m_wb = 0;
    logic [31:0] m_data = '0;
    logic [4:0]  m_rd = '0;
    int          writes = 0, exp_writes = 0;
    bit          adv;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .ext_stall(ext_stall),
        .M_Halt(M_Halt), .M_WriteReg(M_WriteReg), .M_WB(M_WB),
        .M_ReadMem(M_ReadMem), .M_WriteMem(M_WriteMem), .M_JALC(M_JALC),
        .M_Num(M_Num), .M_RegData_2(M_RegData_2), .M_REG(M_REG), .M_PCREG(M_PCREG),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .W_Halt(W_Halt), .W_WriteReg(W_WriteReg), .W_WB(W_WB),
        .W_Data(W_Data), .W_REG(W_REG), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w();
        chk("W_Halt", W_Halt, m_halt);
        chk("W_WriteReg", W_WriteReg, m_wr);
        chk("W_WB", W_WB, m_wb);
        chk("W_Data", W_Data, m_data);
        chk("W_REG", W_REG, m_rd);
        chk("bus_err", bus_err, m_err);
    endtask

    task automatic model_reset();
        m_done = 0; m_miss = 0; m_err = 0;
        m_halt = 0; m_wr = 0; m_wb = 0; m_data = '0; m_rd = '0;
    endtask

    task automatic issue(input int kind, input logic [31:0] num, input logic [31:0] sd,
                         input logic [31:0] pc, input logic [4:0] rd, input bit wr, input bit halt);
        M_ReadMem  = (kind == 0);
        M_WriteMem = (kind == 1);
        M_JALC     = (kind == 3);
        M_Num = num; M_RegData_2 = sd; M_PCREG = pc; M_REG = rd;
        M_WriteReg = wr; M_WB = (kind == 0); M_Halt = halt;
    endtask

    // Called just after a rising edge; ends just after the next rising edge.
    task automatic cycle(input bit rdy, input logic [31:0] rd, input bit xs, output bit advance);
        bit memop, req, tmo, done_now, store;
        dmem_ready = rdy; dmem_rdata = rd; ext_stall = xs;
        #3;
        memop = M_ReadMem | M_WriteMem;
        store = M_WriteMem & ~M_ReadMem;
        req   = memop && !m_done;
        tmo   = 0;
`ifdef MEM_TIMEOUT_EN
        tmo   = req && !rdy && (m_miss == TO);
`endif
        done_now = !m_done && (!memop || rdy || tmo);
        chk("dmem_req", dmem_req, req);
        chk("dmem_we", dmem_we, req && store);
        chk("mem_stall", mem_stall, req && !rdy && !tmo);
        if (req) begin
            chk("dmem_addr", dmem_addr, M_Num);
            chk("dmem_wdata", dmem_wdata, M_RegData_2);
        end
        if (req && store && rdy) exp_writes++;
        if (dmem_req && dmem_we && dmem_ready) writes++;
        if (done_now) begin
            m_halt = M_Halt; m_wr = M_WriteReg; m_wb = M_WB; m_rd = M_REG;
            m_data = M_ReadMem ? (rdy ? rd : 32'h0) : (M_JALC ? M_PCREG : M_Num);
        end else begin
            m_halt = 0; m_wr = 0; m_wb = 0;
        end
        if (tmo) m_err = 1;
        m_miss  = (req && !rdy && !tmo) ? m_miss + 1 : 0;
        advance = (done_now || m_done) && !xs;
        m_done  = (done_now || m_done) && xs;
        @(posedge clock); #1;
        chk_w();
    endtask

    initial begin
        int w0;
        #3;
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_mem_stall", mem_stall, 0);
        chk_w();
        @(posedge clock); #1;
        reset = 1'b1;

        // Zero-wait load
        issue(0, 32'h100, 32'h0, 32'h0, 5'd3, 1, 0);
        cycle(1, 32'h1234_5678, 0, adv);
        chk("t1_W_Data", W_Data, 32'h1234_5678);
        chk("t1_W_WriteReg", W_WriteReg, 1);

        // Store with three wait states: one write only
        w0 = writes;
        issue(1, 32'h200, 32'hCAFE_F00D, 32'h0, 5'd0, 0, 0);
        repeat (3) cycle(0, 32'h0, 0, adv);
        cycle(1, 32'h0, 0, adv);
        chk("t2_store_writes", writes - w0, 1);
        chk("t2_W_WriteReg", W_WriteReg, 0);

        // Load completing under ext_stall: held, not reissued
        w0 = 0;
        issue(0, 32'h300, 32'h0, 32'h0, 5'd7, 1, 0);
        cycle(1, 32'hA5A5_0001, 1, adv);
        cycle(1, 32'hFFFF_FFFF, 1, adv);
        cycle(0, 32'h0, 0, adv);
        chk("t3_W_Data", W_Data, 32'hA5A5_0001);

        // JALC link value, no request
        issue(3, 32'h44, 32'h0, 32'h0040_0008, 5'd31, 1, 0);
        cycle(0, 32'h0, 0, adv);
        chk("t4_W_Data", W_Data, 32'h0040_0008);

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: watchdog completes the load with zero data
        issue(0, 32'h500, 32'h0, 32'h0, 5'd9, 1, 0);
        repeat (TO + 1) cycle(0, 32'hDEAD_BEEF, 0, adv);
        chk("t5_bus_err", bus_err, 1);
        chk("t5_W_Data", W_Data, 32'h0);
        cycle(0, 32'h0, 0, adv);
        chk("t5_bus_err_sticky", bus_err, 1);
`endif

        // Reset asserted mid-WAIT
        issue(0, 32'h600, 32'h0, 32'h0, 5'd12, 1, 1);
        cycle(0, 32'h0, 0, adv);
        cycle(0, 32'h0, 0, adv);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_dmem_req", dmem_req, 0);
        chk("t6_mem_stall", mem_stall, 0);
        chk_w();
        @(posedge clock); #1;
        chk_w();
        reset = 1'b1;
        cycle(1, 32'h0BAD_CAFE, 0, adv);
        chk("t6_W_Data", W_Data, 32'h0BAD_CAFE);

        // Randomized pipeline traffic
        adv = 1;
        for (int n = 0; n < 600; n++) begin
            if (adv) begin
                issue(int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) == 0));
            end
            cycle(($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 3) == 0), adv);
        end
        chk("store_write_count", writes, exp_writes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
